// File: rtl/quadrature_step_decoder.sv
// Quadrature A/B decoder: sync, glitch filter, Gray-phase step strobes.
// Ports: clk, rst, a_in, b_in, clr_err -> enable, up_down, err, ab_state.
module quadrature_step_decoder #(
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       clr_err,
  output logic       enable,
  output logic       up_down,
  output logic       err,
  output logic [1:0] ab_state
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(FILTER_LEN + 4);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);
  localparam logic [SW-1:0] SLAST = SW'(FILTER_LEN + 2);

  typedef enum logic {
    SETTLE,
    RUN
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] scnt;
  logic [1:0]    s1, s2;
  logic          filt [2];
  logic [CW-1:0] cnt  [2];
  logic [1:0]    cur, prev;
  logic          step_up, step_dn, illegal;

  assign cur      = {filt[1], filt[0]};
  assign ab_state = cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {a_in, b_in};
      s2 <= s1;
    end
  end

  // Index 1 is channel A, index 0 is channel B.
  for (genvar i = 0; i < 2; i++) begin : g_filt
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt[i] <= 1'b0;
        cnt[i]  <= '0;
      end else if (state == SETTLE) begin
        filt[i] <= s2[i];
        cnt[i]  <= '0;
      end else if (s2[i] == filt[i]) begin
        cnt[i]  <= '0;
      end else if (cnt[i] == CMAX) begin
        filt[i] <= s2[i];
        cnt[i]  <= '0;
      end else begin
        cnt[i]  <= cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SETTLE;
      scnt  <= '0;
    end else begin
      state <= state_n;
      if (state == SETTLE && scnt != SLAST)
        scnt <= scnt + SW'(1);
    end
  end

  always_comb begin
    state_n = state;
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    unique case (state)
      SETTLE: begin
        if (scnt == SLAST)
          state_n = RUN;
      end
      RUN: begin
        case ({prev, cur})
          4'b0010, 4'b1011,
          4'b1101, 4'b0100: step_up = 1'b1;
          4'b0001, 4'b0111,
          4'b1110, 4'b1000: step_dn = 1'b1;
          4'b0011, 4'b1100,
          4'b0110, 4'b1001: illegal = 1'b1;
          default: ;
        endcase
      end
      default: state_n = SETTLE;
    endcase
  end

  // prev tracks cur in both states, so RUN starts with no phantom step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= '0;
      enable  <= 1'b0;
      up_down <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev   <= cur;
      enable <= step_up | step_dn;
      if (step_up)
        up_down <= 1'b1;
      else if (step_dn)
        up_down <= 1'b0;
      err <= illegal | (err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Scoreboard bench for quadrature_step_decoder, FILTER_LEN=4.
// Stimulus pushes expected strobes; monitor checks them at negedge.
module tb_quadrature_step_decoder;

  logic       clk;
  logic       rst;
  logic       a_in;
  logic       b_in;
  logic       clr_err;
  logic       enable;
  logic       up_down;
  logic       err;
  logic [1:0] ab_state;

  typedef struct {
    logic dir;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  quadrature_step_decoder #(.FILTER_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .b_in     (b_in),
    .clr_err  (clr_err),
    .enable   (enable),
    .up_down  (up_down),
    .err      (err),
    .ab_state (ab_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_chk++;
          n_fail++;
          $display("FAIL strobe_missed: wanted cyc %0d",
                   q[0].cyc);
          void'(q.pop_front());
        end
        if (enable) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL strobe_unexpected: at cyc %0d, wanted none",
                     cyc);
          end else begin
            e = q.pop_front();
            check("strobe_cyc", cyc, e.cyc);
            check("strobe_dir", {31'd0, up_down}, {31'd0, e.dir});
          end
        end
      end
    end
  end

  task automatic drive(input logic a, input logic b,
                       output int c);
    @(negedge clk);
    a_in = a;
    b_in = b;
    c    = cyc;
  endtask

  // Input edge before edge k=c+1; strobe seen after edge k+6.
  task automatic step(input logic a, input logic b,
                      input logic dir);
    int c;
    drive(a, b, c);
    q.push_back('{dir, c + 7});
    repeat (19) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    rst     = 1'b1;
    a_in    = 1'b0;
    b_in    = 1'b0;
    clr_err = 1'b0;
    #3;
    check("rst_enable", {31'd0, enable}, 0);
    check("rst_up_down", {31'd0, up_down}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_ab", {30'd0, ab_state}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(15);

    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("up_ab", {30'd0, ab_state}, 0);
    check("up_err", {31'd0, err}, 0);

    step(1'b0, 1'b1, 1'b0);
    check("dn1_dir", {31'd0, up_down}, 0);
    step(1'b1, 1'b1, 1'b0);
    check("dn2_dir", {31'd0, up_down}, 0);
    step(1'b1, 1'b0, 1'b0);
    check("dn3_dir", {31'd0, up_down}, 0);
    step(1'b0, 1'b0, 1'b0);
    check("dn4_dir", {31'd0, up_down}, 0);
    check("dn_ab", {30'd0, ab_state}, 0);

    drive(1'b1, 1'b0, c);
    idle(3);
    a_in = 1'b0;
    idle(20);
    check("glitch3_ab", {30'd0, ab_state}, 0);

    drive(1'b1, 1'b0, c);
    q.push_back('{1'b1, c + 7});
    idle(4);
    a_in = 1'b0;
    q.push_back('{1'b0, c + 11});
    idle(20);
    check("glitch4_ab", {30'd0, ab_state}, 0);
    check("glitch4_dir", {31'd0, up_down}, 0);

    drive(1'b1, 1'b1, c);
    idle(20);
    check("ill_err", {31'd0, err}, 1);
    check("ill_ab", {30'd0, ab_state}, 3);
    idle(10);
    check("ill_err_hold", {31'd0, err}, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err", {31'd0, err}, 0);

    drive(1'b0, 1'b0, c);
    idle(6);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("set_wins", {31'd0, err}, 1);
    idle(5);
    check("set_wins_ab", {30'd0, ab_state}, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err2", {31'd0, err}, 0);

    @(negedge clk);
    rst  = 1'b1;
    a_in = 1'b1;
    b_in = 1'b1;
    #1;
    check("rst11_ab", {30'd0, ab_state}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(8);
    check("settle11_ab", {30'd0, ab_state}, 3);
    check("settle11_err", {31'd0, err}, 0);
    idle(10);

    drive(1'b0, 1'b0, c);
    idle(20);
    check("pre_rst_err", {31'd0, err}, 1);
    drive(1'b1, 1'b0, c);
    q.push_back('{1'b1, c + 7});
    idle(7);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_enable", {31'd0, enable}, 0);
    check("midrst_up_down", {31'd0, up_down}, 0);
    check("midrst_err", {31'd0, err}, 0);
    check("midrst_ab", {30'd0, ab_state}, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(15);
    check("post_rst_ab", {30'd0, ab_state}, 2);
    check("post_rst_err", {31'd0, err}, 0);

    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
